// File: rtl/uartlite_pkg.sv
// Shared definitions for the AXI UART Lite TX writer: register map, STAT bits,
// AXI response codes and the writer FSM state type.
package uartlite_pkg;

    localparam logic [3:0] TXF_OFFS_DEF  = 4'h4;
    localparam logic [3:0] STAT_OFFS_DEF = 4'h8;

    localparam int STAT_RXV = 0;
    localparam int STAT_RXF = 1;
    localparam int STAT_TXE = 2;
    localparam int STAT_TXF = 3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } tx_state_e;

endpackage

// File: rtl/axi_uartlite_tx_writer.sv
// AXI4-Lite initiator pushing one byte at a time into a UART Lite TX FIFO,
// optionally polling STAT until the FIFO has room before each write.
module axi_uartlite_tx_writer
    import uartlite_pkg::*;
#(
    parameter int                ADDR_W      = 4,
    parameter logic [ADDR_W-1:0] TXF_OFFS    = ADDR_W'(TXF_OFFS_DEF),
    parameter logic [ADDR_W-1:0] STAT_OFFS   = ADDR_W'(STAT_OFFS_DEF),
    parameter bit                POLL_STATUS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] m_axi_awaddr_o,
    output logic              m_axi_awvalid_o,
    input  logic              m_axi_awready_i,
    output logic [31:0]       m_axi_wdata_o,
    output logic [3:0]        m_axi_wstrb_o,
    output logic              m_axi_wvalid_o,
    input  logic              m_axi_wready_i,
    input  logic [1:0]        m_axi_bresp_i,
    input  logic              m_axi_bvalid_i,
    output logic              m_axi_bready_o,
    output logic [ADDR_W-1:0] m_axi_araddr_o,
    output logic              m_axi_arvalid_o,
    input  logic              m_axi_arready_i,
    input  logic [31:0]       m_axi_rdata_i,
    input  logic [1:0]        m_axi_rresp_i,
    input  logic              m_axi_rvalid_i,
    output logic              m_axi_rready_o
);

    // Handshakes: a channel transfers on the clock edge where valid && ready;
    // valids are held with stable addr/data until that edge and never withdrawn.

    tx_state_e   state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;

    // Only the TX-full bit of STAT steers the FSM.
    logic unused_rdata;
    assign unused_rdata = ^{m_axi_rdata_i[31:STAT_TXF+1], m_axi_rdata_i[STAT_TXF-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            byte_q    <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        byte_d    = byte_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_valid_i) begin
                    byte_d    = byte_data_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = POLL_STATUS ? ST_AR : ST_AW_W;
                end
            end
            ST_AR: begin
                if (m_axi_arready_i) state_d = ST_R;
            end
            ST_R: begin
                if (m_axi_rvalid_i) begin
                    // A failed status read still lets the byte through.
                    if (m_axi_rresp_i != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_AW_W;
                    end else if (m_axi_rdata_i[STAT_TXF]) begin
                        state_d = ST_AR;
                    end else begin
                        state_d = ST_AW_W;
                    end
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q | m_axi_awready_i;
                w_done_d  = w_done_q | m_axi_wready_i;
                if (aw_done_d && w_done_d) state_d = ST_B;
            end
            ST_B: begin
                if (m_axi_bvalid_i) begin
                    if (m_axi_bresp_i != RESP_OKAY) err_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready_o    = (state_q == ST_IDLE);
        busy_o          = (state_q != ST_IDLE);
        err_o           = err_q;
        m_axi_araddr_o  = STAT_OFFS;
        m_axi_arvalid_o = (state_q == ST_AR);
        m_axi_rready_o  = (state_q == ST_R);
        m_axi_awaddr_o  = TXF_OFFS;
        m_axi_awvalid_o = (state_q == ST_AW_W) && !aw_done_q;
        m_axi_wdata_o   = {24'h000000, byte_q};
        m_axi_wstrb_o   = 4'h1;
        m_axi_wvalid_o  = (state_q == ST_AW_W) && !w_done_q;
        m_axi_bready_o  = (state_q == ST_B);
    end

endmodule
